// File: rtl/usb_msg_streamer_pkg.sv
// Shared constants, state encoding and ASCII helper for the message streamer.
package usb_msg_streamer_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;
    localparam logic [7:0] ASCII_NUL        = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_HEX   = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_e;

    // Uppercase ASCII character for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + 8'(nib);
        end
        return ASCII_A_MINUS_10 + 8'(nib);
    endfunction

endpackage

// File: rtl/usb_msg_streamer_msg_rom.sv
// Message ROM with a registered read port (one-cycle latency, no reset so it
// maps onto block RAM). The image is slot-major: byte i of slot s sits at
// bits [8*(s*MSG_LEN_MAX+i) +: 8] of MSG_INIT.
module usb_msg_streamer_msg_rom #(
    parameter int unsigned MSG_COUNT   = 4,
    parameter int unsigned MSG_LEN_MAX = 16,
    parameter logic [8*MSG_COUNT*MSG_LEN_MAX-1:0] MSG_INIT = '0,
    localparam int unsigned DEPTH = MSG_COUNT * MSG_LEN_MAX,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [7:0]    data_o
);

    logic [7:0] data_q;

    // Synchronous read of the addressed byte.
    always_ff @(posedge clk_i) begin
        data_q <= MSG_INIT[{addr_i, 3'b000} +: 8];
    end

    assign data_o = data_q;

endmodule

// File: rtl/usb_msg_streamer.sv
// Streams one ROM string per start (trigger or auto-repeat) over a
// valid/ready byte interface, optionally followed by uppercase hex digits of a
// latched value, always terminated by CR LF.
module usb_msg_streamer
    import usb_msg_streamer_pkg::*;
#(
    parameter int unsigned MSG_COUNT    = 4,
    parameter int unsigned MSG_LEN_MAX  = 16,
    parameter int unsigned HEX_DIGITS   = 4,
    parameter int unsigned PERIOD_WIDTH = 26,
    parameter logic [8*MSG_COUNT*MSG_LEN_MAX-1:0] MSG_INIT = '0,
    localparam int unsigned SELW = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
    localparam int unsigned VALW = 4 * HEX_DIGITS
) (
    input  logic            clk_48mhz,
    input  logic            reset_n,
    input  logic [SELW-1:0] msg_sel,
    input  logic [VALW-1:0] value,
    input  logic            hex_en,
    input  logic            trigger,
    input  logic            auto_en,
    output logic [7:0]      uart_in_data,
    output logic            uart_in_valid,
    input  logic            uart_in_ready,
    output logic            busy,
    output logic            done
);

    localparam int unsigned IDXW  = $clog2(MSG_LEN_MAX + 1);
    localparam int unsigned DIGW  = $clog2(HEX_DIGITS + 1);
    localparam int unsigned DEPTH = MSG_COUNT * MSG_LEN_MAX;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                  state_q, state_d;
    logic [SELW-1:0]         sel_q, sel_d;
    logic [VALW-1:0]         val_q, val_d;
    logic                    hex_en_q, hex_en_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [DIGW-1:0]         dig_q, dig_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    start_c;
    logic                    accept_c;
    logic                    text_end_c;
    logic                    sel_ok_c;
    logic [7:0]              rom_data;
    logic [IDXW-1:0]         rom_idx_c;
    logic [AW-1:0]           rom_addr_c;
    logic [DIGW-1:0]         nib_sel_c;
    logic [3:0]              nib_c;

    assign start_c    = trigger | (auto_en & (&period_q));
    assign accept_c   = valid_q & uart_in_ready;
    assign text_end_c = (rom_data == ASCII_NUL) || (idx_q == IDXW'(MSG_LEN_MAX));
    assign sel_ok_c   = 32'(msg_sel) < MSG_COUNT;

    // ROM is addressed from next-state values so FETCH sees the byte at (sel_q, idx_q).
    assign rom_idx_c  = (idx_d == IDXW'(MSG_LEN_MAX)) ? '0 : idx_d;
    assign rom_addr_c = AW'(sel_d) * AW'(MSG_LEN_MAX) + AW'(rom_idx_c);

    // First digit comes from FETCH (top nibble); later digits from the decremented counter.
    assign nib_sel_c = ((state_q == ST_HEX) && (dig_q != '0)) ? dig_q - DIGW'(1)
                                                              : DIGW'(HEX_DIGITS - 1);
    assign nib_c     = val_q[{nib_sel_c, 2'b00} +: 4];

    usb_msg_streamer_msg_rom #(
        .MSG_COUNT   (MSG_COUNT),
        .MSG_LEN_MAX (MSG_LEN_MAX),
        .MSG_INIT    (MSG_INIT)
    ) u_msg_rom (
        .clk_i  (clk_48mhz),
        .addr_i (rom_addr_c),
        .data_o (rom_data)
    );

    // State register.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_c) state_d = ST_FETCH;
            ST_FETCH: begin
                if (text_end_c) begin
                    state_d = hex_en_q ? ST_HEX : ST_CR;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND:  if (accept_c) state_d = ST_FETCH;
            ST_HEX:   if (accept_c && (dig_q == '0)) state_d = ST_CR;
            ST_CR:    if (accept_c) state_d = ST_LF;
            ST_LF:    if (accept_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        sel_d    = sel_q;
        val_d    = val_q;
        hex_en_d = hex_en_q;
        idx_d    = idx_q;
        dig_d    = dig_q;
        period_d = period_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                period_d = auto_en ? period_q + PERIOD_WIDTH'(1) : '0;
                if (start_c) begin
                    period_d = '0;
                    sel_d    = sel_ok_c ? msg_sel : '0;
                    val_d    = value;
                    hex_en_d = hex_en;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                valid_d = 1'b1;
                if (!text_end_c) begin
                    data_d = rom_data;
                end else if (hex_en_q) begin
                    dig_d  = DIGW'(HEX_DIGITS - 1);
                    data_d = hex_ascii(nib_c);
                end else begin
                    data_d = ASCII_CR;
                end
            end
            ST_SEND: begin
                if (accept_c) begin
                    valid_d = 1'b0;
                    idx_d   = idx_q + IDXW'(1);
                end
            end
            ST_HEX: begin
                if (accept_c) begin
                    if (dig_q == '0) begin
                        data_d = ASCII_CR;
                    end else begin
                        dig_d  = dig_q - DIGW'(1);
                        data_d = hex_ascii(nib_c);
                    end
                end
            end
            ST_CR: begin
                if (accept_c) data_d = ASCII_LF;
            end
            ST_LF: begin
                if (accept_c) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= '0;
            val_q    <= '0;
            hex_en_q <= 1'b0;
            idx_q    <= '0;
            dig_q    <= '0;
            period_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            val_q    <= val_d;
            hex_en_q <= hex_en_d;
            idx_q    <= idx_d;
            dig_q    <= dig_d;
            period_q <= period_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign uart_in_data  = data_q;
    assign uart_in_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
